rx_dc_corr_multi: RTL and testbench
===================================

// Module: rx_dc_corr_multi
// PURPOSE
//  Next-generation RX DC-offset corrector for CHANS parallel I/Q channel pairs. Sits between ADC sign-extension and CORDIC/FIR.
//  Each lane has a leaky-integrator DC estimate, subtracted with saturation. Correction modes: bypass, track, hold, manual.
//  Adds valid/ready backpressure, runtime loop bandwidth, per-lane estimate readback and a saturation event counter.
// PARAMETERS
//  WIDTH      16  sample width per lane (signed two's complement)
//  CHANS      1   number of I/Q pairs; lanes = 2*CHANS, lane 2k = I, lane 2k+1 = Q
//  MAX_SHIFT  15  largest integrator shift; ACC_W = WIDTH+MAX_SHIFT+1
//  SATCNT_W   16  width of saturation event counter
// PORTS
//  clk           in   1                  block clock (single domain)
//  rst           in   1                  asynchronous, active-high reset
//  in_data       in   2*CHANS*WIDTH      lane n at [n*WIDTH +: WIDTH]
//  in_valid      in   1                  input beat valid
//  in_ready      out  1                  input beat accepted when in_valid && in_ready
//  out_data      out  2*CHANS*WIDTH      corrected samples, same lane packing
//  out_valid     out  1                  output beat valid
//  out_ready     in   1                  downstream accept
//  cfg_mode      in   2                  0 BYPASS, 1 TRACK, 2 HOLD, 3 MANUAL (applies to all lanes)
//  cfg_shift     in   4                  integrator shift s; values > MAX_SHIFT clamp to MAX_SHIFT
//  cfg_manual    in   2*CHANS*WIDTH      per-lane DC value used in MANUAL
//  cfg_satcnt_clr in  1                  synchronous clear of sat_cnt
//  corr_vals     out  2*CHANS*WIDTH      per-lane DC value currently subtracted (est_used)
//  sat_cnt       out  SATCNT_W           saturating count of output beats with any lane clipped
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, acc=0 all lanes, corr_vals=0, sat_cnt=0; in_ready=1 after release.
//  Pipeline: 2 register stages, S1 (subtract) -> S2 (saturate/output). Latency = 2 clk from accepted beat to out_valid, no stall.
//  Advance: adv = !out_valid || out_ready. in_ready = adv (stage-1 empty slot also passes through). No beat dropped or duplicated.
//    With in_valid held and out_ready=1, throughput is 1 beat/clk. With out_ready=0, out_data/out_valid stay stable.
//  Estimate: est = acc >>> s (arithmetic). est_used per mode:
//    BYPASS est_used=0; TRACK/HOLD est_used=est; MANUAL est_used=cfg_manual lane.
//  Integrator update happens only on an accepted input beat:
//    TRACK   acc <= acc + sext(x) - est
//    HOLD    acc unchanged
//    MANUAL  acc <= sext(cfg_manual) << s  (so MANUAL->TRACK resumes from manual value)
//    BYPASS  acc <= 0
//  Mode and cfg_shift are sampled per accepted beat. A cfg_shift change does not rescale acc; the resulting transient is accepted.
//  Output: y = x - est_used computed in WIDTH+1 bits, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//    sat_cnt += 1 for each output beat with any clamped lane, counted at the S2 load; it sticks at all-ones.
//    cfg_satcnt_clr has priority over an increment in the same clk.
//  corr_vals updates with the beat that used it and is registered alongside S1.
//  Mode change mid-stream takes effect on the next accepted beat. Beats already in S1/S2 keep their values.
//  Reset mid-operation discards in-flight beats. Downstream sees out_valid fall asynchronously.
// STRUCTURE
//  Package rx_dsp_pkg: mode constants (DC_BYPASS=0, DC_TRACK=1, DC_HOLD=2, DC_MANUAL=3) and a sat_clamp function.
//  Sub-module dc_corr_lane: one lane of acc, est_used, subtract and clamp, with a clip flag out. Generate 2*CHANS instances.
//  Top level owns the handshake, the shared advance enable and sat_cnt.
// TESTING
//  1 TRACK, s=4, constant input 1000 on all lanes, out_ready=1: output decays toward 0, |y|<=16 within 200 beats; corr_vals -> ~1000.
//  2 BYPASS, random data: out_data == in_data delayed 2 clk, corr_vals=0, sat_cnt stays 0.
//  3 MANUAL, cfg_manual=-32768, input 32767: y clamps to 32767 each beat, sat_cnt counts beats;
//    clear pulse with a concurrent clip reads 0.
//  4 Backpressure: random out_ready (50%) with continuous in_valid: output sequence equals the ideal model,
//    no loss or duplication, and data is stable while stalled.
//  5 TRACK converged to 500, then HOLD with input step to 0: y = -500 constant and corr_vals frozen;
//    return to TRACK: estimate decays from 500.
//  6 Assert rst mid-stream with out_valid=1: out_valid=0 immediately, acc=0; first post-reset beat has est_used=0.

Source files
------------

// File: rtl/rx_dsp_pkg.sv
// Shared DC-correction mode encoding and the signed saturation helper used by the RX datapath.
package rx_dsp_pkg;

    typedef enum logic [1:0] {
        DC_BYPASS = 2'd0,
        DC_TRACK  = 2'd1,
        DC_HOLD   = 2'd2,
        DC_MANUAL = 2'd3
    } dc_mode_e;

    // Clamp v to the signed range of a w-bit value (w <= 32).
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v,
                                                     input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/dc_corr_lane.sv
// One correction lane: leaky-integrator DC estimate, subtract (S1) and saturate (S2).
module dc_corr_lane
    import rx_dsp_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_SHIFT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_s2_load,
    input  logic [1:0]       i_mode,
    input  logic [3:0]       i_shift,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_manual,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_corr,
    output logic             o_clip
);
    localparam int unsigned ACC_W = WIDTH + MAX_SHIFT + 1;

    dc_mode_e                w_mode;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_est;
    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_man_ext;
    logic signed [WIDTH-1:0] w_est_used;
    logic signed [WIDTH-1:0] r_corr;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH:0]   r_diff;
    logic signed [31:0]      w_diff_ext;
    logic signed [31:0]      w_clamped;
    logic [WIDTH-1:0]        r_y;

    assign w_mode = dc_mode_e'(i_mode);

    always_comb begin
        w_x_ext    = ACC_W'($signed(i_x));
        w_man_ext  = ACC_W'($signed(i_manual));
        w_est      = r_acc >>> i_shift;
        w_est_used = '0;
        w_acc_next = r_acc;
        unique case (w_mode)
            DC_BYPASS: begin
                w_est_used = '0;
                w_acc_next = '0;
            end
            DC_TRACK: begin
                w_est_used = WIDTH'(w_est);
                w_acc_next = r_acc + w_x_ext - w_est;
            end
            DC_HOLD: begin
                w_est_used = WIDTH'(w_est);
            end
            DC_MANUAL: begin
                // Preload so a later switch to TRACK resumes from the manual value.
                w_est_used = $signed(i_manual);
                w_acc_next = w_man_ext <<< i_shift;
            end
            default: begin
                w_est_used = '0;
            end
        endcase
        w_diff = (WIDTH + 1)'($signed(i_x)) - (WIDTH + 1)'(w_est_used);
    end

    assign w_diff_ext = 32'(r_diff);
    assign w_clamped  = sat_clamp(w_diff_ext, WIDTH);
    assign o_clip     = (w_clamped != w_diff_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_diff <= '0;
            r_corr <= '0;
            r_y    <= '0;
        end else begin
            if (i_load) begin
                r_acc  <= w_acc_next;
                r_diff <= w_diff;
                r_corr <= w_est_used;
            end
            if (i_s2_load) begin
                r_y <= WIDTH'(w_clamped);
            end
        end
    end

    assign o_y    = r_y;
    assign o_corr = r_corr;

endmodule

// File: rtl/rx_dc_corr_multi.sv
// Multi-lane RX DC-offset corrector: shared valid/ready handshake, per-lane correction, clip counter.
module rx_dc_corr_multi
    import rx_dsp_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANS     = 1,
    parameter int unsigned MAX_SHIFT = 15,
    parameter int unsigned SATCNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*CHANS*WIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [2*CHANS*WIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [1:0]               cfg_mode,
    input  logic [3:0]               cfg_shift,
    input  logic [2*CHANS*WIDTH-1:0] cfg_manual,
    input  logic                     cfg_satcnt_clr,
    output logic [2*CHANS*WIDTH-1:0] corr_vals,
    output logic [SATCNT_W-1:0]      sat_cnt
);
    localparam int unsigned LANES = 2 * CHANS;

    logic                w_adv;
    logic                w_load;
    logic                w_s2_load;
    logic [3:0]          w_shift;
    logic [LANES-1:0]    w_clip;
    logic                r_s1_valid;
    logic                r_out_valid;
    logic [SATCNT_W-1:0] r_sat_cnt;

    // One enable moves both stages, so a bubble in S1 is overwritten rather than held.
    assign w_adv     = !r_out_valid || out_ready;
    assign w_load    = in_valid && w_adv;
    assign w_s2_load = w_adv && r_s1_valid;
    assign w_shift   = (32'(cfg_shift) > MAX_SHIFT) ? 4'(MAX_SHIFT) : cfg_shift;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dc_corr_lane #(
            .WIDTH    (WIDTH),
            .MAX_SHIFT(MAX_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_load),
            .i_s2_load(w_s2_load),
            .i_mode   (cfg_mode),
            .i_shift  (w_shift),
            .i_x      (in_data[g*WIDTH +: WIDTH]),
            .i_manual (cfg_manual[g*WIDTH +: WIDTH]),
            .o_y      (out_data[g*WIDTH +: WIDTH]),
            .o_corr   (corr_vals[g*WIDTH +: WIDTH]),
            .o_clip   (w_clip[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sat_cnt   <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_out_valid <= r_s1_valid;
            end
            if (cfg_satcnt_clr) begin
                r_sat_cnt <= '0;
            end else if (w_s2_load && (|w_clip) && !(&r_sat_cnt)) begin
                r_sat_cnt <= r_sat_cnt + SATCNT_W'(1);
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_rx_dc_corr_multi.sv
// Directed bench for rx_dc_corr_multi: hand-computed vector table plus streaming/backpressure sequences.
module tb_rx_dc_corr_multi;
    localparam int W  = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    cfg_mode;
    logic [3:0]    cfg_shift;
    logic [DW-1:0] cfg_manual;
    logic          cfg_satcnt_clr;
    logic [DW-1:0] corr_vals;
    logic [15:0]   sat_cnt;

    rx_dc_corr_multi #(
        .WIDTH    (16),
        .CHANS    (1),
        .MAX_SHIFT(15),
        .SATCNT_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .cfg_mode      (cfg_mode),
        .cfg_shift     (cfg_shift),
        .cfg_manual    (cfg_manual),
        .cfg_satcnt_clr(cfg_satcnt_clr),
        .corr_vals     (corr_vals),
        .sat_cnt       (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] shift;
        int         x0, x1, m0, m1;
        logic       clr;
        int         y0, y1, c0, c1, sat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    vec_t          tbl [15];
    vec_t          post[2];
    exp_t          q[$];
    longint        m_acc[2];
    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] last_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_acc[0] = 0;
        m_acc[1] = 0;
    endtask

    // Behavioural reference of one accepted beat on both lanes.
    task automatic model_beat(input logic [1:0] mode, input int s, input logic [DW-1:0] x,
                              input logic [DW-1:0] man, output logic [DW-1:0] y);
        for (int l = 0; l < 2; l++) begin
            longint xv, mv, est, eu, v;
            xv  = longint'($signed(x[l*W +: W]));
            mv  = longint'($signed(man[l*W +: W]));
            est = m_acc[l] >>> s;
            case (mode)
                2'd0: begin eu = 0; m_acc[l] = 0; end
                2'd1: begin eu = est; m_acc[l] = m_acc[l] + xv - est; end
                2'd2: begin eu = est; end
                default: begin eu = mv; m_acc[l] = mv <<< s; end
            endcase
            v = xv - eu;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            y[l*W +: W] = 16'(v);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        cfg_mode       = v.mode;
        cfg_shift      = v.shift;
        in_data        = {16'(v.x1), 16'(v.x0)};
        cfg_manual     = {16'(v.m1), 16'(v.m0)};
        cfg_satcnt_clr = v.clr;
        in_valid       = 1'b1;
        out_ready      = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 cfg_satcnt_clr = 1'b0;
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " out_data"}, out_data, {16'(v.y1), 16'(v.y0)});
        check({tag, " corr_vals"}, corr_vals, {16'(v.c1), 16'(v.c0)});
        check({tag, " sat_cnt"}, sat_cnt, 16'(v.sat));
    endtask

    // kind 0: full-range random, 1: constant (c0,c1), 2: random in +-2000.
    task automatic run_stream(input string tag, input int n, input logic [1:0] mode,
                              input logic [3:0] sh, input int kind, input int c0, input int c1,
                              input bit rnd_ready, input bit chk_lat);
        int            sent, got, cyc;
        bit            have, prev_stall, acc_in, acc_out;
        logic [DW-1:0] prev_data, pred;
        exp_t          e;
        sent = 0; got = 0; cyc = 0; have = 0; prev_stall = 0; prev_data = '0;
        cfg_mode = mode;
        cfg_shift = sh;
        while (got < n && cyc < n * 10 + 50) begin
            if (!have && sent < n) begin
                if (kind == 0) in_data = $urandom;
                else if (kind == 1) in_data = {16'(c1), 16'(c0)};
                else in_data = {16'(int'($urandom_range(0, 4000)) - 2000),
                                16'(int'($urandom_range(0, 4000)) - 2000)};
                have = 1;
            end
            in_valid  = have;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall) check({tag, " stall hold"}, out_data, prev_data);
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL %s extra beat: got %0h expected none", tag, out_data);
                end else begin
                    e = q.pop_front();
                    check({tag, " data"}, out_data, e.d);
                    if (chk_lat) check({tag, " latency"}, 64'(cyc - e.cyc), 2);
                end
                last_out = out_data;
                got++;
            end
            if (acc_in) begin
                model_beat(mode, int'(sh), in_data, cfg_manual, pred);
                q.push_back('{d: pred, cyc: cyc});
                sent++;
                have = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk);
            #1 cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_rng({tag, " beats delivered"}, got, n, n);
        q.delete();
    endtask

    initial begin
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1; cfg_mode = 2'd0; cfg_shift = 4'd4;
        cfg_manual = '0; cfg_satcnt_clr = 1'b0; last_out = '0;

        //          mode  sh     x0      x1      m0      m1   clr  y0      y1      c0      c1   sat
        tbl[0]  = '{2'd0, 4'd4,  100,    -200,   0,      0,     0, 100,    -200,   0,      0,     0};
        tbl[1]  = '{2'd1, 4'd4,  1600,   -1600,  0,      0,     0, 1600,   -1600,  0,      0,     0};
        tbl[2]  = '{2'd1, 4'd4,  1600,   -1600,  0,      0,     0, 1500,   -1500,  100,    -100,  0};
        tbl[3]  = '{2'd2, 4'd4,  0,      0,      0,      0,     0, -193,   194,    193,    -194,  0};
        tbl[4]  = '{2'd2, 4'd2,  0,      0,      0,      0,     0, -775,   775,    775,    -775,  0};
        tbl[5]  = '{2'd3, 4'd3,  5,      5,      10,     -20,   0, -5,     25,     10,     -20,   0};
        tbl[6]  = '{2'd1, 4'd3,  90,     -150,   0,      0,     0, 80,     -130,   10,     -20,   0};
        tbl[7]  = '{2'd3, 4'd0,  32767,  -32768, -32768, 32767, 0, 32767,  -32768, -32768, 32767, 1};
        tbl[8]  = '{2'd3, 4'd0,  32767,  -32768, -32768, 32767, 0, 32767,  -32768, -32768, 32767, 2};
        tbl[9]  = '{2'd3, 4'd0,  32767,  0,      -32768, 0,     0, 32767,  0,      -32768, 0,     3};
        tbl[10] = '{2'd3, 4'd0,  32767,  0,      -32768, 0,     1, 32767,  0,      -32768, 0,     0};
        tbl[11] = '{2'd3, 4'd0,  32767,  0,      -32768, 0,     0, 32767,  0,      -32768, 0,     1};
        tbl[12] = '{2'd0, 4'd0,  -32768, 32767,  0,      0,     0, -32768, 32767,  0,      0,     1};
        tbl[13] = '{2'd1, 4'd15, 32767,  -32768, 0,      0,     0, 32767,  -32768, 0,      0,     1};
        tbl[14] = '{2'd1, 4'd15, 0,      0,      0,      0,     0, 0,      1,      0,      -1,    1};
        post[0] = '{2'd1, 4'd4,  1000,   1000,   0,      0,     0, 1000,   1000,   0,      0,     0};
        post[1] = '{2'd1, 4'd4,  1000,   1000,   0,      0,     0, 938,    938,    62,     62,    0};

        do_reset();
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset corr_vals", corr_vals, 0);
        check("reset sat_cnt", sat_cnt, 0);
        check("reset in_ready", in_ready, 1);

        for (int i = 0; i < 15; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Bypass: identity with two-cycle latency, no correction, no clips.
        do_reset();
        run_stream("bypass", 20, 2'd0, 4'd4, 0, 0, 0, 1'b0, 1'b1);
        check("bypass corr_vals", corr_vals, 0);
        check("bypass sat_cnt", sat_cnt, 0);

        // Track a constant offset, then hold it across an input step, then resume tracking.
        do_reset();
        run_stream("conv1000", 200, 2'd1, 4'd4, 1, 1000, 1000, 1'b0, 1'b0);
        check_rng("conv1000 y0", int'($signed(last_out[15:0])), -16, 16);
        check_rng("conv1000 y1", int'($signed(last_out[31:16])), -16, 16);
        check_rng("conv1000 corr0", int'($signed(corr_vals[15:0])), 984, 1000);
        run_stream("conv500", 400, 2'd1, 4'd4, 1, 500, 500, 1'b0, 1'b0);
        run_stream("hold", 5, 2'd2, 4'd4, 1, 0, 0, 1'b0, 1'b0);
        check("hold y", last_out, 32'hFE0C_FE0C);
        check("hold corr_vals", corr_vals, 32'h01F4_01F4);
        run_stream("retrack", 3, 2'd1, 4'd4, 1, 0, 0, 1'b0, 1'b0);
        check_rng("retrack y0", int'($signed(last_out[15:0])), -499, -1);
        check_rng("retrack corr0", int'($signed(corr_vals[15:0])), 400, 499);

        // Random downstream backpressure with continuous input.
        do_reset();
        run_stream("bp", 80, 2'd1, 4'd3, 2, 0, 0, 1'b1, 1'b0);

        // Reset while a beat is being presented downstream.
        cfg_mode  = 2'd0;
        in_data   = 32'h1234_5678;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 check("pre-reset out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset out_data", out_data, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        apply_vec(post[0], "post-reset0");
        apply_vec(post[1], "post-reset1");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
